// File: rtl/alarm_ram_pkg.sv
// Shared types and default widths for the alarm RAM arbiter and its round-robin helper.
package alarm_ram_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/alarm_ram_arbiter_rr_arb2.sv
// Two-requester round-robin: a lone requester wins, a tie goes to the side not granted last.
module rr_arb2
  import alarm_ram_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic advance,
  output logic grant,
  output logic valid
);

  logic r_last_grant;

  always_comb begin
    grant = GRANT_A;
    if (req_a && req_b) begin
      grant = ~r_last_grant;
    end else if (req_b) begin
      grant = GRANT_B;
    end
    valid = req_a | req_b;
  end

  // Starting from B makes A the winner of the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= GRANT_B;
    end else if (advance && valid) begin
      r_last_grant <= grant;
    end
  end

endmodule

// File: rtl/alarm_ram_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port 2048x32 RAM with one-cycle read latency.
module alarm_ram_arbiter
  import alarm_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = BE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  state_t            r_state;
  state_t            w_next;
  logic              w_grant;
  logic              w_gvalid;
  logic              w_accept;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [BE_W-1:0]   w_sel_be;
  logic [DATA_W-1:0] w_sel_wdata;

  logic              r_op_wr;
  logic              r_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic              r_cs;
  logic              r_we;
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;
  logic              r_rv_a;
  logic              r_rv_b;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_a   (a_read | a_write),
    .req_b   (b_read | b_write),
    .advance (w_accept),
    .grant   (w_grant),
    .valid   (w_gvalid)
  );

  // Acceptance is suppressed while reset is asserted so waitrequest stays high.
  assign w_accept = (r_state == IDLE) && w_gvalid && !reset;

  always_comb begin
    w_sel_wr    = a_write;
    w_sel_addr  = a_address;
    w_sel_be    = a_byteenable;
    w_sel_wdata = a_writedata;
    if (w_grant == GRANT_B) begin
      w_sel_wr    = b_write;
      w_sel_addr  = b_address;
      w_sel_be    = b_byteenable;
      w_sel_wdata = b_writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = ISSUE;
      ISSUE:   w_next = r_op_wr ? IDLE : WAIT;
      WAIT:    w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture; the RAM strobe is live for exactly the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_wr <= 1'b0;
      r_gnt   <= GRANT_A;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_cs <= w_accept;
      r_we <= w_accept && w_sel_wr;
      if (w_accept) begin
        r_op_wr <= w_sel_wr;
        r_gnt   <= w_grant;
        r_addr  <= w_sel_addr;
        r_be    <= w_sel_be;
        r_wdata <= w_sel_wdata;
      end
    end
  end

  // Read return: RAM data is sampled in WAIT, strobed to the owner in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
      r_rv_a    <= 1'b0;
      r_rv_b    <= 1'b0;
    end else begin
      r_rv_a <= (r_state == WAIT) && (r_gnt == GRANT_A);
      r_rv_b <= (r_state == WAIT) && (r_gnt == GRANT_B);
      if (r_state == WAIT) begin
        if (r_gnt == GRANT_A) r_rdata_a <= ram_readdata;
        else                  r_rdata_b <= ram_readdata;
      end
    end
  end

  assign a_waitrequest   = !(w_accept && (w_grant == GRANT_A));
  assign b_waitrequest   = !(w_accept && (w_grant == GRANT_B));
  assign a_readdata      = r_rdata_a;
  assign b_readdata      = r_rdata_b;
  assign a_readdatavalid = r_rv_a;
  assign b_readdatavalid = r_rv_b;
  assign ram_address     = r_addr;
  assign ram_byteenable  = r_be;
  assign ram_writedata   = r_wdata;
  assign ram_chipselect  = r_cs;
  assign ram_write       = r_we;
  assign ram_clken       = 1'b1;

endmodule

// File: tb/tb_alarm_ram_arbiter.sv
// Bench for alarm_ram_arbiter: RAM model, transaction-level reference model, directed scenarios.
module tb_alarm_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] a_address = '0, b_address = '0;
  logic [3:0]  a_byteenable = '0, b_byteenable = '0;
  logic        a_read = 1'b0, a_write = 1'b0, b_read = 1'b0, b_write = 1'b0;
  logic [31:0] a_writedata = '0, b_writedata = '0;
  logic        a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
  logic [31:0] a_readdata, b_readdata;
  logic [10:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata = '0;

  alarm_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read), .a_write(a_write),
    .a_writedata(a_writedata), .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read), .b_write(b_write),
    .b_writedata(b_writedata), .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 20000) begin
      $display("FAIL watchdog: got cycle %0d, expected below 20000", cyc);
      $fatal(1, "watchdog");
    end
  end

  // Single-port RAM, one-cycle registered read.
  logic [31:0] ram_mem [0:2047];
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int i = 0; i < 4; i++)
          if (ram_byteenable[i]) ram_mem[ram_address][8*i +: 8] <= ram_writedata[8*i +: 8];
      end else begin
        ram_readdata <= ram_mem[ram_address];
      end
    end
  end

  // Reference model: who is accepted when, and what each port must show on later cycles.
  logic [31:0] m_mem [0:2047];
  bit          s_cs [0:4095];
  bit          s_we [0:4095];
  bit          s_rv_a [0:4095];
  bit          s_rv_b [0:4095];
  logic [31:0] s_dat [0:4095];
  logic [10:0] s_addr [0:4095];
  logic [3:0]  s_be [0:4095];
  logic [31:0] s_wd [0:4095];
  logic [31:0] m_rd_a, m_rd_b;
  bit          m_last;
  bit          rst_prev = 1'b1;
  int          m_free = 0;
  bit          dut_log[$];
  bit          m_log[$];
  int          cnt_rv_a = 0, cnt_rv_b = 0, cnt_we = 0;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram_mem[i] = '0;
      m_mem[i] = '0;
    end
    for (int i = 0; i < 4096; i++) begin
      s_cs[i] = 0; s_we[i] = 0; s_rv_a[i] = 0; s_rv_b[i] = 0;
      s_dat[i] = '0; s_addr[i] = '0; s_be[i] = '0; s_wd[i] = '0;
    end
  end

  always @(negedge clk) begin
    bit pa, pb, won, win, e_wa, e_wb, w;
    logic [10:0] ad;
    logic [3:0]  be;
    logic [31:0] wd;
    if (cyc > 0) begin
      if (rst_prev) begin
        m_rd_a = '0;
        m_rd_b = '0;
        m_last = 1'b1;
      end
      if (s_rv_a[cyc]) m_rd_a = s_dat[cyc];
      if (s_rv_b[cyc]) m_rd_b = s_dat[cyc];
      pa = a_read | a_write;
      pb = b_read | b_write;
      won = 0; win = 0; e_wa = 1; e_wb = 1;
      if (!reset && cyc >= m_free && (pa || pb)) begin
        won = 1;
        win = (pa && pb) ? !m_last : pb;
        if (win) e_wb = 0; else e_wa = 0;
      end
      chk("a_waitrequest", a_waitrequest, e_wa);
      chk("b_waitrequest", b_waitrequest, e_wb);
      chk("ram_chipselect", ram_chipselect, s_cs[cyc]);
      chk("ram_write", ram_write, s_we[cyc]);
      chk("ram_clken", ram_clken, 1);
      if (s_cs[cyc]) begin
        chk("ram_address", ram_address, s_addr[cyc]);
        chk("ram_byteenable", ram_byteenable, s_be[cyc]);
        chk("ram_writedata", ram_writedata, s_wd[cyc]);
      end
      chk("a_readdatavalid", a_readdatavalid, s_rv_a[cyc]);
      chk("b_readdatavalid", b_readdatavalid, s_rv_b[cyc]);
      chk("a_readdata", a_readdata, m_rd_a);
      chk("b_readdata", b_readdata, m_rd_b);
      if (!a_waitrequest) dut_log.push_back(1'b0);
      if (!b_waitrequest) dut_log.push_back(1'b1);
      if (a_readdatavalid) cnt_rv_a++;
      if (b_readdatavalid) cnt_rv_b++;
      if (ram_chipselect && ram_write) cnt_we++;
      if (won) begin
        w  = win ? b_write : a_write;
        ad = win ? b_address : a_address;
        be = win ? b_byteenable : a_byteenable;
        wd = win ? b_writedata : a_writedata;
        m_log.push_back(win);
        m_last = win;
        s_cs[cyc+1] = 1; s_we[cyc+1] = w;
        s_addr[cyc+1] = ad; s_be[cyc+1] = be; s_wd[cyc+1] = wd;
        if (w) begin
          for (int i = 0; i < 4; i++)
            if (be[i]) m_mem[ad][8*i +: 8] = wd[8*i +: 8];
          m_free = cyc + 2;
        end else begin
          if (win) s_rv_b[cyc+3] = 1; else s_rv_a[cyc+3] = 1;
          s_dat[cyc+3] = m_mem[ad];
          m_free = cyc + 4;
        end
      end
      if (reset) begin
        for (int k = 1; k <= 4; k++) begin
          s_cs[cyc+k] = 0; s_we[cyc+k] = 0; s_rv_a[cyc+k] = 0; s_rv_b[cyc+k] = 0;
        end
        m_free = cyc + 1;
      end
    end
    rst_prev = reset;
  end

  // Drivers: hold a request until the side is accepted, then drop it after the edge.
  task automatic req_a(input bit rd, input bit wr, input logic [10:0] ad,
                       input logic [31:0] wd, input logic [3:0] be);
    bit ok = 0;
    a_read = rd; a_write = wr; a_address = ad; a_writedata = wd; a_byteenable = be;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (!a_waitrequest) ok = 1;
    end
    if (!ok) chk("a_accept_timeout", 0, 1);
    @(posedge clk); #1;
    a_read = 0; a_write = 0;
  endtask

  task automatic req_b(input bit rd, input bit wr, input logic [10:0] ad,
                       input logic [31:0] wd, input logic [3:0] be);
    bit ok = 0;
    b_read = rd; b_write = wr; b_address = ad; b_writedata = wd; b_byteenable = be;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (!b_waitrequest) ok = 1;
    end
    if (!ok) chk("b_accept_timeout", 0, 1);
    @(posedge clk); #1;
    b_read = 0; b_write = 0;
  endtask

  task automatic wait_rv(input bit side, output logic [31:0] d);
    bit ok = 0;
    d = '0;
    for (int k = 0; k < 16 && !ok; k++) begin
      @(negedge clk);
      if (!side && a_readdatavalid) begin ok = 1; d = a_readdata; end
      if (side && b_readdatavalid) begin ok = 1; d = b_readdata; end
    end
    if (!ok) chk("readdatavalid_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  order;
    int          base_a, base_b, base_we;

    @(posedge clk); @(negedge clk);
    chk("reset_a_waitrequest", a_waitrequest, 1);
    chk("reset_b_waitrequest", b_waitrequest, 1);
    chk("reset_chipselect", ram_chipselect, 0);
    chk("reset_clken", ram_clken, 1);
    @(posedge clk); #1;
    reset = 0;
    idle(1);

    // Write then read back on A.
    req_a(0, 1, 11'h010, 32'hDEADBEEF, 4'hF);
    req_a(1, 0, 11'h010, 32'h0, 4'hF);
    wait_rv(0, d);
    chk("a_read_0x010", d, 32'hDEADBEEF);
    chk("model_rd_a_0x010", m_rd_a, 32'hDEADBEEF);
    chk("b_rv_count_after_a", cnt_rv_b, 0);

    // Partial byte-lane write, read by B.
    req_a(0, 1, 11'h7FF, 32'h11223344, 4'hF);
    req_a(0, 1, 11'h7FF, 32'hAABBCCDD, 4'h3);
    req_b(1, 0, 11'h7FF, 32'h0, 4'h0);
    wait_rv(1, d);
    chk("b_read_0x7FF", d, 32'h1122CCDD);

    // Continuous reads from both sides must alternate.
    dut_log.delete();
    m_log.delete();
    base_a = cnt_rv_a;
    base_b = cnt_rv_b;
    fork
      begin
        req_a(1, 0, 11'h010, 0, 4'hF); req_a(1, 0, 11'h7FF, 0, 4'hF);
        req_a(1, 0, 11'h010, 0, 4'hF); req_a(1, 0, 11'h7FF, 0, 4'hF);
      end
      begin
        req_b(1, 0, 11'h7FF, 0, 4'hF); req_b(1, 0, 11'h010, 0, 4'hF);
        req_b(1, 0, 11'h7FF, 0, 4'hF); req_b(1, 0, 11'h010, 0, 4'hF);
      end
    join
    idle(5);
    chk("rr_grant_count", dut_log.size(), 8);
    order = '0;
    for (int i = 0; i < 8 && i < dut_log.size(); i++) order[i] = dut_log[i];
    chk("rr_dut_order", order, 8'hAA);
    order = '0;
    for (int i = 0; i < 8 && i < m_log.size(); i++) order[i] = m_log[i];
    chk("rr_model_order", order, 8'hAA);
    chk("rr_a_valid_pulses", cnt_rv_a - base_a, 4);
    chk("rr_b_valid_pulses", cnt_rv_b - base_b, 4);

    // Read and write together: only the write happens.
    base_a = cnt_rv_a;
    base_we = cnt_we;
    req_a(1, 1, 11'h020, 32'h5, 4'hF);
    idle(5);
    chk("rw_write_cycles", cnt_we - base_we, 1);
    chk("rw_no_readdatavalid", cnt_rv_a - base_a, 0);
    req_a(1, 0, 11'h020, 32'h0, 4'hF);
    wait_rv(0, d);
    chk("read_back_0x020", d, 32'h5);

    // Reset while a B read sits in WAIT.
    base_b = cnt_rv_b;
    req_b(1, 0, 11'h7FF, 32'h0, 4'hF);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    idle(4);
    chk("reset_mid_read_no_valid", cnt_rv_b - base_b, 0);
    chk("reset_b_readdata_cleared", b_readdata, 0);
    dut_log.delete();
    fork
      req_a(1, 0, 11'h010, 0, 4'hF);
      req_b(1, 0, 11'h010, 0, 4'hF);
    join
    idle(6);
    chk("post_reset_tie_first", (dut_log.size() > 0) ? {31'b0, dut_log[0]} : 32'hFFFF_FFFF, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
